// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: memory freeze, taken-branch flush and load-use bubble
// insertion for a 5-stage pipeline, with saturating stall/flush statistics.
module pipe_hazard_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned STAT_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [4:0]        ex_rd,
    input  logic              ex_memread,
    input  logic              ex_branch_taken,
    input  logic              dmem_req,
    input  logic              dmem_ready,
    output logic              pc_stall,
    output logic              if_id_stall,
    output logic              if_id_flush,
    output logic              id_ex_flush,
    output logic              ex_mem_stall,
    output logic [1:0]        state,
    output logic [STAT_W-1:0] stall_cnt,
    output logic [STAT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StMemWait = 2'd1,
        StFlush   = 2'd2
    } state_e;

    localparam logic [2:0] RELOAD = 3'(FLUSH_CYCLES - 1);
    localparam bit         SINGLE = (FLUSH_CYCLES == 1);

    state_e            r_state;
    state_e            w_state_nxt;
    logic [2:0]        r_cd;
    logic [2:0]        w_cd_nxt;
    logic              w_freeze;
    logic              w_load_use;
    logic              w_accept_br;
    logic [STAT_W-1:0] r_stall_cnt;
    logic [STAT_W-1:0] r_flush_cnt;

    assign w_freeze   = dmem_req & ~dmem_ready;
    assign w_load_use = ex_memread && (ex_rd != 5'd0) &&
                        ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                         (id_use_rs2 && (id_rs2 == ex_rd)));

    always_comb begin
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_stall = 1'b0;
        w_accept_br  = 1'b0;
        w_state_nxt  = StRun;
        w_cd_nxt     = r_cd;
        case (r_state)
            StFlush: begin
                if (w_freeze) begin
                    pc_stall     = 1'b1;
                    if_id_stall  = 1'b1;
                    ex_mem_stall = 1'b1;
                    w_state_nxt  = StFlush;
                end else if (ex_branch_taken) begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    w_accept_br = 1'b1;
                    w_cd_nxt    = RELOAD;
                    w_state_nxt = SINGLE ? StRun : StFlush;
                end else begin
                    if_id_flush = 1'b1;
                    w_cd_nxt    = (r_cd <= 3'd1) ? 3'd0 : r_cd - 3'd1;
                    w_state_nxt = (r_cd <= 3'd1) ? StRun : StFlush;
                end
            end
            default: begin
                w_cd_nxt = 3'd0;
                // MEM_WAIT keeps freezing until ready, even if dmem_req drops
                if (w_freeze || ((r_state == StMemWait) && !dmem_ready)) begin
                    pc_stall     = 1'b1;
                    if_id_stall  = 1'b1;
                    ex_mem_stall = 1'b1;
                    w_state_nxt  = StMemWait;
                end else if (ex_branch_taken) begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    w_accept_br = 1'b1;
                    w_cd_nxt    = RELOAD;
                    w_state_nxt = SINGLE ? StRun : StFlush;
                end else if (w_load_use) begin
                    pc_stall    = 1'b1;
                    if_id_stall = 1'b1;
                    id_ex_flush = 1'b1;
                end
                // Encoding 3 decodes as RUN but always returns to RUN
                if (r_state == state_e'(2'd3)) begin
                    w_state_nxt = StRun;
                    w_cd_nxt    = 3'd0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= StRun;
            r_cd        <= 3'd0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cd    <= w_cd_nxt;
            if (pc_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + STAT_W'(1);
            end
            if (w_accept_br && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + STAT_W'(1);
            end
        end
    end

    assign state     = r_state;
    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus randomized traffic
// compared cycle by cycle against a behavioural model of the hazard rules.
module tb_pipe_hazard_ctrl;

    localparam int unsigned FC   = 3;
    localparam int unsigned SW   = 4;
    localparam int          SMAX = 15;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [4:0]    id_rs1, id_rs2, ex_rd;
    logic          id_use_rs1, id_use_rs2, ex_memread, ex_branch_taken;
    logic          dmem_req, dmem_ready;
    logic          pc_stall, if_id_stall, if_id_flush, id_ex_flush, ex_mem_stall;
    logic [1:0]    state;
    logic [SW-1:0] stall_cnt, flush_cnt;
    logic [4:0]    w_ctrl;
    logic [4:0]    last_ctrl;

    int n_total = 0;
    int n_bad   = 0;

    // Model: mode 0=run 1=waiting on memory 2=flushing; left = flush cycles still owed
    int         m_state, m_left, m_stall, m_flush;
    int         nx_state, nx_left;
    bit         nx_acc;
    logic [4:0] exp_ctrl;

    pipe_hazard_ctrl #(
        .FLUSH_CYCLES(FC),
        .STAT_W      (SW)
    ) u_dut (
        .clk            (clk),
        .rst            (rst),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_use_rs1     (id_use_rs1),
        .id_use_rs2     (id_use_rs2),
        .ex_rd          (ex_rd),
        .ex_memread     (ex_memread),
        .ex_branch_taken(ex_branch_taken),
        .dmem_req       (dmem_req),
        .dmem_ready     (dmem_ready),
        .pc_stall       (pc_stall),
        .if_id_stall    (if_id_stall),
        .if_id_flush    (if_id_flush),
        .id_ex_flush    (id_ex_flush),
        .ex_mem_stall   (ex_mem_stall),
        .state          (state),
        .stall_cnt      (stall_cnt),
        .flush_cnt      (flush_cnt)
    );

    assign w_ctrl = {pc_stall, if_id_stall, if_id_flush, id_ex_flush, ex_mem_stall};

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle();
        id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
        id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_memread = 1'b0;
        ex_branch_taken = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
    endtask

    task automatic model_reset();
        m_state = 0; m_left = 0; m_stall = 0; m_flush = 0;
    endtask

    task automatic model_eval();
        bit frz, lu;
        frz = dmem_req && !dmem_ready;
        lu  = ex_memread && (ex_rd != 0) &&
              ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
        exp_ctrl = 5'b00000; nx_acc = 0; nx_state = 0; nx_left = 0;
        if (m_state == 2) begin
            if (frz) begin
                exp_ctrl = 5'b11001; nx_state = 2; nx_left = m_left;
            end else if (ex_branch_taken) begin
                exp_ctrl = 5'b00110; nx_acc = 1; nx_left = FC - 1;
                nx_state = (nx_left > 0) ? 2 : 0;
            end else begin
                exp_ctrl = 5'b00100; nx_left = m_left - 1;
                nx_state = (nx_left > 0) ? 2 : 0;
                if (nx_left < 0) nx_left = 0;
            end
        end else if (frz || (m_state == 1 && !dmem_ready)) begin
            exp_ctrl = 5'b11001; nx_state = 1;
        end else if (ex_branch_taken) begin
            exp_ctrl = 5'b00110; nx_acc = 1; nx_left = FC - 1;
            nx_state = (nx_left > 0) ? 2 : 0;
        end else if (lu) begin
            exp_ctrl = 5'b11010;
        end
    endtask

    task automatic model_commit();
        m_state = nx_state;
        m_left  = nx_left;
        if (exp_ctrl[4] && m_stall < SMAX) m_stall++;
        if (nx_acc && m_flush < SMAX) m_flush++;
    endtask

    // Called just after a falling edge with inputs already applied
    task automatic cycle();
        #1;
        model_eval();
        check("ctrl", w_ctrl, exp_ctrl);
        last_ctrl = w_ctrl;
        @(posedge clk);
        model_commit();
        #1;
        check("state", state, m_state);
        check("stall_cnt", stall_cnt, m_stall);
        check("flush_cnt", flush_cnt, m_flush);
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        #1;
        check("rst_state", state, 0);
        check("rst_ctrl", w_ctrl, 0);
        #1;
        rst = 1'b0;
        model_reset();
        @(negedge clk);
    endtask

    initial begin
        int n_iff, n_idex;
        idle();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check("reset_state", state, 0);
        check("reset_stall_cnt", stall_cnt, 0);
        check("reset_flush_cnt", flush_cnt, 0);
        check("reset_ctrl", w_ctrl, 0);
        rst = 1'b0;

        // Load-use on rs2
        ex_memread = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_use_rs2 = 1'b1;
        #1 check("lu_ctrl", w_ctrl, 5'b11010);
        cycle();
        check("lu_stall_cnt", stall_cnt, 1);
        check("lu_state", state, 0);
        idle();
        cycle();

        // Phantom hazards
        do_reset();
        ex_memread = 1'b1; ex_rd = 5'd0; id_rs2 = 5'd0; id_use_rs2 = 1'b1;
        #1 check("phantom_rd0", w_ctrl, 0);
        cycle();
        ex_rd = 5'd5; id_rs2 = 5'd5; id_use_rs2 = 1'b0;
        #1 check("phantom_nouse", w_ctrl, 0);
        cycle();
        idle();

        // Memory wait for 3 cycles, then ready
        do_reset();
        dmem_req = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 check("mw_freeze", w_ctrl, 5'b11001);
            cycle();
            check("mw_state", state, 1);
        end
        dmem_ready = 1'b1;
        #1 check("mw_ready_ctrl", w_ctrl, 0);
        cycle();
        check("mw_done_state", state, 0);
        check("mw_stall_cnt", stall_cnt, 3);
        idle();

        // Taken branch with three flush cycles
        do_reset();
        n_iff = 0; n_idex = 0;
        ex_branch_taken = 1'b1;
        cycle();
        n_iff += int'(last_ctrl[2]); n_idex += int'(last_ctrl[1]);
        ex_branch_taken = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            n_iff += int'(last_ctrl[2]); n_idex += int'(last_ctrl[1]);
        end
        check("br_iff_cycles", n_iff, 3);
        check("br_idex_cycles", n_idex, 1);
        check("br_flush_cnt", flush_cnt, 1);
        check("br_state", state, 0);

        // Branch beats load-use; freeze beats branch
        do_reset();
        ex_branch_taken = 1'b1; ex_memread = 1'b1; ex_rd = 5'd7;
        id_rs1 = 5'd7; id_use_rs1 = 1'b1;
        #1 check("br_lu_ctrl", w_ctrl, 5'b00110);
        cycle();
        idle();
        repeat (3) cycle();
        dmem_req = 1'b1; dmem_ready = 1'b0; ex_branch_taken = 1'b1;
        #1 check("frz_br_ctrl", w_ctrl, 5'b11001);
        cycle();
        check("frz_br_flush_cnt", flush_cnt, 1);
        dmem_ready = 1'b1; ex_branch_taken = 1'b0;
        cycle();
        idle();
        cycle();

        // Asynchronous reset in MEM_WAIT, then in FLUSH
        dmem_req = 1'b1; dmem_ready = 1'b0;
        cycle();
        cycle();
        check("ar_pre_state", state, 1);
        #2 rst = 1'b1;
        #1;
        check("ar_mw_state", state, 0);
        check("ar_mw_stall_cnt", stall_cnt, 0);
        check("ar_mw_flush_cnt", flush_cnt, 0);
        idle();
        #1 rst = 1'b0;
        model_reset();
        @(negedge clk);
        ex_branch_taken = 1'b1;
        cycle();
        ex_branch_taken = 1'b0;
        check("ar_pre_flush", state, 2);
        #2 rst = 1'b1;
        #1;
        check("ar_fl_state", state, 0);
        check("ar_fl_flush_cnt", flush_cnt, 0);
        #1 rst = 1'b0;
        model_reset();
        @(negedge clk);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            id_rs1          = 5'($urandom_range(0, 3));
            id_rs2          = 5'($urandom_range(0, 3));
            ex_rd           = 5'($urandom_range(0, 3));
            id_use_rs1      = 1'($urandom_range(0, 1));
            id_use_rs2      = 1'($urandom_range(0, 1));
            ex_memread      = ($urandom_range(0, 4) < 2);
            ex_branch_taken = ($urandom_range(0, 6) == 0);
            dmem_req        = ($urandom_range(0, 3) == 0);
            dmem_ready      = 1'($urandom_range(0, 1));
            cycle();
        end

        // Stall counter saturation
        idle();
        dmem_req = 1'b1;
        repeat (20) cycle();
        check("sat_stall_cnt", stall_cnt, SMAX);
        idle();
        dmem_ready = 1'b1;
        cycle();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
